// File: rtl/ps2_kb_tx.sv
// PS/2 device-side transmitter: sends one keypress (make, F0, break) per accepted scan code,
// generating kb_clk itself and holding both lines high while idle and between frames.
module ps2_kb_tx #(
    parameter int CLK_HALF = 50,
    parameter int GAP      = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sc_in,
    input  logic       sc_valid,
    output logic       sc_ready,
    output logic       kb_clk,
    output logic       kb_data,
    output logic       busy,
    output logic       frame_done
);

    localparam int TMAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_HALF - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP - 1);
    localparam logic [7:0]    BREAK_CODE = 8'hF0;
    localparam logic [3:0]    LAST_BIT   = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [3:0]      bit_cnt, bit_cnt_nxt;
    logic [1:0]      frame_cnt, frame_cnt_nxt;
    logic            kb_clk_nxt, kb_data_nxt, sc_ready_nxt, frame_done_nxt;
    logic [7:0]      code_q, code_nxt;
    logic [9:0]      shreg, shreg_nxt;

    // Bits that follow the start bit, in send order from bit 0: data LSB first, odd parity, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            frame_cnt  <= '0;
            kb_clk     <= 1'b1;
            kb_data    <= 1'b1;
            sc_ready   <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            bit_cnt    <= bit_cnt_nxt;
            frame_cnt  <= frame_cnt_nxt;
            kb_clk     <= kb_clk_nxt;
            kb_data    <= kb_data_nxt;
            sc_ready   <= sc_ready_nxt;
            busy       <= ~sc_ready_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Payload registers carry no reset; they are always loaded before being shifted out.
    always_ff @(posedge clk) begin
        code_q <= code_nxt;
        shreg  <= shreg_nxt;
    end

    always_comb begin
        state_nxt      = state;
        timer_nxt      = timer;
        bit_cnt_nxt    = bit_cnt;
        frame_cnt_nxt  = frame_cnt;
        kb_clk_nxt     = kb_clk;
        kb_data_nxt    = kb_data;
        sc_ready_nxt   = sc_ready;
        frame_done_nxt = 1'b0;
        code_nxt       = code_q;
        shreg_nxt      = shreg;

        unique case (state)
            S_IDLE: begin
                if (sc_valid) begin
                    code_nxt      = sc_in;
                    shreg_nxt     = frame_bits(sc_in);
                    kb_data_nxt   = 1'b0;
                    bit_cnt_nxt   = '0;
                    frame_cnt_nxt = '0;
                    timer_nxt     = '0;
                    sc_ready_nxt  = 1'b0;
                    state_nxt     = S_HIGH;
                end
            end
            S_HIGH: begin
                if (timer == HALF_LAST) begin
                    timer_nxt  = '0;
                    kb_clk_nxt = 1'b0;
                    state_nxt  = S_LOW;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_LOW: begin
                if (timer == HALF_LAST) begin
                    timer_nxt  = '0;
                    kb_clk_nxt = 1'b1;
                    if (bit_cnt < LAST_BIT) begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        kb_data_nxt = shreg[0];
                        shreg_nxt   = {1'b1, shreg[9:1]};
                        state_nxt   = S_HIGH;
                    end else begin
                        frame_done_nxt = 1'b1;
                        state_nxt      = S_GAP;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_nxt = '0;
                    if (frame_cnt < 2'd2) begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                        shreg_nxt     = frame_bits((frame_cnt == 2'd0) ? BREAK_CODE : code_q);
                        bit_cnt_nxt   = '0;
                        kb_data_nxt   = 1'b0;
                        state_nxt     = S_HIGH;
                    end else begin
                        sc_ready_nxt = 1'b1;
                        state_nxt    = S_IDLE;
                    end
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: doc/ps2_kb_tx.md
# ps2_kb_tx

Synthesizable PS/2 device-side transmitter that emulates a keyboard keypress. It accepts one scan code over a valid/ready handshake and sends three device-to-host frames on kb_clk/kb_data: make (code), break prefix (F0), and break (code). It generates the PS/2 clock itself. It drives keyboard_top directly in on-board loopback tests, replacing the external keyboard.

## Interface
Parameters:
- CLK_HALF, 50: system clocks per kb_clk half-period. Use 2500 for about 10 kHz at 50 MHz. Minimum 2.
- GAP, 200: idle system clocks after each frame, with kb_clk and kb_data held high. Minimum 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sc_in  in  8  scan code to send. Sampled only on accept.
- sc_valid  in  1  scan code request.
- sc_ready  out  1  block can accept a request. Accept happens on a clk edge with sc_valid && sc_ready.
- kb_clk  out  1  generated PS/2 clock. Idle high.
- kb_data  out  1  PS/2 serial data. Idle high.
- busy  out  1  transaction in progress. Equals ~sc_ready.
- frame_done  out  1  one-cycle pulse at the end of each frame's stop bit.

## Operation
- Frame format: 11 bits, sent LSB first.
  - Start bit 0.
  - data[0..7].
  - Odd parity bit, equal to ~^data.
  - Stop bit 1.
- One transaction is three frames, in order: sc_in, 8'hF0, sc_in. A frame counter (0..2) selects the byte. sc_in is latched into a holding register on accept.
- State machine: IDLE, HIGH, LOW, GAP.
  - IDLE: sc_ready=1. On accept: latch code, load frame 0 shift register, kb_data<=start bit (0), bit counter<=0, timer<=0, sc_ready<=0, go to HIGH.
  - HIGH: kb_clk=1. After CLK_HALF cycles: kb_clk<=0, go to LOW.
  - LOW: kb_clk=0. After CLK_HALF cycles: kb_clk<=1.
    - If bit counter < 10: increment it, kb_data<=next bit, go to HIGH.
    - Else: pulse frame_done, go to GAP. kb_data stays 1 from the stop bit.
  - GAP: after GAP cycles:
    - If frame counter < 2: increment it, load next byte, kb_data<=0, go to HIGH.
    - Else: sc_ready<=1, go to IDLE.
- kb_data changes only on the clk edge where kb_clk rises, or on accept. It is therefore stable for CLK_HALF cycles before every kb_clk falling edge, which is where the receiver samples.
- sc_valid and sc_in are ignored while busy. There is no abort input.

## Timing
- Reset values (asynchronous): kb_clk=1, kb_data=1, sc_ready=1, busy=0, frame_done=0. State is IDLE and all counters are 0.
- Reset mid-frame:
  - Outputs return to idle immediately.
  - The partial frame is abandoned.
  - After reset release, no frames are sent until a new accept.
- Let t0 be the accept edge and H=CLK_HALF. Edge times for frame k (k=0..2), with base Tk = t0 + k*(22H+GAP):
  - Start bit is driven at Tk.
  - Falling edge of bit i is at Tk + (2i+1)H.
  - Rising edge of bit i is at Tk + (2i+2)H.
  - frame_done is high for the single cycle following Tk+22H.
- sc_ready rises at t0 + 66H + 3*GAP. A new accept is possible on that edge or later.
- Registered outputs only. No combinational path from any input to any output.

## Test plan
- Reset hold: rst high for 3 cycles, then released with sc_valid=0.
  - kb_clk=1, kb_data=1, sc_ready=1, busy=0.
  - No kb_clk edges for 1000 cycles.
- Single key 0x1C: accept, then sample kb_data on each kb_clk fall.
  - Frames decode as 0x1C (parity 0), 0xF0 (parity 1), 0x1C (parity 0).
  - All stop bits are 1.
  - frame_done pulses exactly 3 times.
  - With CLK_HALF=50 and GAP=200, sc_ready returns exactly 3900 cycles after accept.
- Loopback into keyboard_top with codes 0x00, 0xFF, 0x1C, 0x32 back-to-back, sc_valid held high.
  - Receiver sc output shows each code, then F0, then the code, in sequence.
  - Parity bits are 1, 1, 0, 0 respectively.
- sc_in changed from 0x1C to 0x45 one cycle after accept, with sc_valid pulsed during busy.
  - The transaction still sends 0x1C.
  - No extra transaction starts.
  - busy stays high throughout.
- rst asserted mid-frame (bit 5 of frame 1):
  - kb_clk and kb_data go high asynchronously, with no further edges.
  - After release, a new accept of 0x2B produces three clean frames starting from frame 0.
- Edge timing check with CLK_HALF=2 and GAP=1:
  - Every kb_data transition coincides with a kb_clk rise.
  - kb_data is stable for at least 2 cycles before every kb_clk fall.
